// File: rtl/rect_fill.sv
// Rectangle fill pixel generator for the VGA adapter: plots a clamped rectangle
// column-major, one pixel per clock, with a start/done handshake. RECT_FILL_STRIPE_EN selects x-striped colour.
module rect_fill #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       done,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] x1,
  input  logic [6:0] y1,
  input  logic [2:0] colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [7:0] XMAX = 8'(SCREEN_W - 1);
  localparam logic [6:0] YMAX = 7'(SCREEN_H - 1);

  state_t     state_q;
  logic [7:0] cx_q, x1_q;
  logic [6:0] cy_q, y0_q, y1_q;
  logic       done_q, plot_q;
  logic [7:0] vx_q;
  logic [6:0] vy_q;
  logic [2:0] vc_q;
`ifndef RECT_FILL_STRIPE_EN
  logic [2:0] colour_q;
`endif

  logic [7:0] x0_d, x1_d;
  logic [6:0] y0_d, y1_d;

  always_comb begin
    x0_d = (x0 > XMAX) ? XMAX : x0;
    x1_d = (x1 > XMAX) ? XMAX : x1;
    y0_d = (y0 > YMAX) ? YMAX : y0;
    y1_d = (y1 > YMAX) ? YMAX : y1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
`ifndef RECT_FILL_STRIPE_EN
      colour_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          plot_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            cx_q <= x0_d;
            cy_q <= y0_d;
            x1_q <= x1_d;
            y0_q <= y0_d;
            y1_q <= y1_d;
`ifndef RECT_FILL_STRIPE_EN
            colour_q <= colour;
`endif
            state_q <= ((x0_d > x1_d) || (y0_d > y1_d)) ? DONE : FILL;
          end
        end
        FILL: begin
          plot_q <= 1'b1;
          vx_q   <= cx_q;
          vy_q   <= cy_q;
`ifdef RECT_FILL_STRIPE_EN
          vc_q   <= cx_q[2:0];
`else
          vc_q   <= colour_q;
`endif
          // column-major scan: y runs fastest, x steps when a column completes
          if (cy_q == y1_q) begin
            cy_q <= y0_q;
            cx_q <= cx_q + 8'd1;
            if (cx_q == x1_q) state_q <= DONE;
          end else begin
            cy_q <= cy_q + 7'd1;
          end
        end
        DONE: begin
          plot_q <= 1'b0;
          if (start) begin
            done_q <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done       = done_q;
  assign vga_plot   = plot_q;
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = vc_q;

endmodule

// File: tb/tb_rect_fill.sv
// Randomised self-checking bench for rect_fill against a pixel-list reference model.
module tb_rect_fill;

  logic       clk = 1'b0;
  logic       rst, start, done, vga_plot;
  logic [7:0] x0, x1, vga_x;
  logic [6:0] y0, y1, vga_y;
  logic [2:0] colour, vga_colour;

  rect_fill #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour(colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int c; } pix_t;
  pix_t exp_q[$];
  pix_t obs_q[$];
  int   checks = 0;
  int   errors = 0;
  int   maxx, maxy;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference: list every pixel of the clamped rectangle in column-major order
  task automatic build_model(input int ax0, ay0, ax1, ay1, acol);
    int lx, rx, ty, by;
    exp_q.delete();
    lx = clampi(ax0, 159); rx = clampi(ax1, 159);
    ty = clampi(ay0, 119); by = clampi(ay1, 119);
    for (int x = lx; x <= rx; x++)
      for (int y = ty; y <= by; y++) begin
`ifdef RECT_FILL_STRIPE_EN
        exp_q.push_back('{x, y, x % 8});
`else
        exp_q.push_back('{x, y, acol});
`endif
      end
  endtask

  function automatic int obs_coord(input int idx, input bit want_y);
    if (idx < 0 || idx >= obs_q.size()) return -1;
    return want_y ? obs_q[idx].y : obs_q[idx].x;
  endfunction

  task automatic run_fill(input string name, input int ax0, ay0, ax1, ay1, acol,
                          input int hold, input bit chg);
    int n, c, first, done_cyc, bad, both, hold_bad;
    build_model(ax0, ay0, ax1, ay1, acol);
    n = exp_q.size();
    @(negedge clk);
    x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1); colour = 3'(acol);
    start = 1'b1;
    obs_q.delete();
    first = -1; done_cyc = -1; c = 0; both = 0;
    while (done_cyc < 0 && c < n + 10) begin
      @(negedge clk);
      c++;
      if (chg && c == 5) begin
        colour = ~3'(acol); x1 = 8'd0; y1 = 7'd0;
      end
      if (vga_plot) begin
        if (first < 0) first = c;
        obs_q.push_back('{int'(vga_x), int'(vga_y), int'(vga_colour)});
        if (done) both = 1;
      end
      if (done) done_cyc = c;
    end
    check({name, " first_plot_cycle"}, first, (n == 0) ? -1 : 2);
    check({name, " plot_count"}, obs_q.size(), n);
    check({name, " done_cycle"}, done_cyc, n + 2);
    check({name, " plot_with_done"}, both, 0);
    bad = 0; maxx = 0; maxy = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].x > maxx) maxx = obs_q[i].x;
      if (obs_q[i].y > maxy) maxy = obs_q[i].y;
      if (i >= n || obs_q[i] != exp_q[i]) bad++;
    end
    check({name, " pixel_mismatches"}, bad, 0);
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (done !== 1'b1 || vga_plot !== 1'b0) hold_bad++;
    end
    if (hold > 0) check({name, " hold_done"}, hold_bad, 0);
    start = 1'b0;
    @(negedge clk);
    check({name, " done_cleared"}, done, 0);
    check({name, " idle_no_plot"}, vga_plot, 0);
  endtask

  initial begin
    int cnt, c, ax0, ay0, ax1, ay1, stray;
    rst = 1'b1; start = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour = '0;
    repeat (3) @(negedge clk);
    check("reset done", done, 0);
    check("reset plot", vga_plot, 0);
    check("reset x", vga_x, 0);
    check("reset y", vga_y, 0);
    check("reset colour", vga_colour, 0);
    rst = 1'b0;

    run_fill("full", 0, 0, 159, 119, 3, 0, 1'b0);
    check("full p0.x", obs_coord(0, 0), 0);
    check("full p0.y", obs_coord(0, 1), 0);
    check("full p1.x", obs_coord(1, 0), 0);
    check("full p1.y", obs_coord(1, 1), 1);
    check("full p120.x", obs_coord(120, 0), 1);
    check("full p120.y", obs_coord(120, 1), 0);
    check("full last.x", obs_coord(19199, 0), 159);
    check("full last.y", obs_coord(19199, 1), 119);

    run_fill("single", 10, 20, 10, 20, 5, 0, 1'b0);
    run_fill("clamp", 150, 110, 200, 127, 6, 0, 1'b0);
    check("clamp max_x", maxx, 159);
    check("clamp max_y", maxy, 119);
    run_fill("empty", 50, 10, 40, 20, 2, 0, 1'b0);
    run_fill("handshake", 20, 30, 24, 35, 1, 5, 1'b1);

    // reset during a full-screen fill
    @(negedge clk);
    x0 = 8'd0; y0 = 7'd0; x1 = 8'd159; y1 = 7'd119; colour = 3'd3; start = 1'b1;
    cnt = 0; c = 0;
    while (cnt < 37 && c < 200) begin
      @(negedge clk);
      c++;
      if (vga_plot) cnt++;
    end
    check("midrst plots_before", cnt, 37);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check("midrst plot", vga_plot, 0);
    check("midrst done", done, 0);
    rst = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (vga_plot !== 1'b0 || done !== 1'b0) stray++;
    end
    check("midrst quiet", stray, 0);
    run_fill("restart", 0, 0, 1, 1, 4, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      ax0 = $urandom_range(0, 200);
      ax1 = $urandom_range((ax0 >= 15) ? ax0 - 15 : 0, (ax0 + 20 > 255) ? 255 : ax0 + 20);
      ay0 = $urandom_range(0, 127);
      ay1 = $urandom_range((ay0 >= 10) ? ay0 - 10 : 0, (ay0 + 15 > 127) ? 127 : ay0 + 15);
      run_fill($sformatf("rand%0d", t), ax0, ay0, ax1, ay1, $urandom_range(0, 7),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_fill.md
Name: rect_fill

Overview:
- Pixel-generator stage that feeds the VGA adapter in the lab4 display path.
- On a start pulse it plots every pixel of an axis-aligned rectangle on the 160x120 frame, one pixel per clock, driving the adapter's x/y/colour/plot inputs.
- Generalises the full-screen fill: a full-screen clear is the rectangle (0,0)-(159,119).
- Uses a start/done handshake so the task-level top FSM can sequence it with later drawing stages.

Parameters:
- SCREEN_W, 160, frame width in pixels; valid x is 0..SCREEN_W-1.
- SCREEN_H, 120, frame height in pixels; valid y is 0..SCREEN_H-1.

Ports:
- clk  input  1  system clock (CLOCK_50 at the top level)
- rst  input  1  synchronous active-high reset
- start  input  1  request a fill; level-sensitive
- done  output  1  fill complete; held until start is deasserted
- x0  input  8  left column, inclusive
- y0  input  7  top row, inclusive
- x1  input  8  right column, inclusive
- y1  input  7  bottom row, inclusive
- colour  input  3  fill colour
- vga_x  output  8  plot column to VGA adapter
- vga_y  output  7  plot row to VGA adapter
- vga_colour  output  3  plot colour
- vga_plot  output  1  write strobe, one pixel per asserted cycle

Behaviour:
- Reset and outputs:
  - Reset is synchronous and active-high on clk.
  - All outputs are registered.
  - Reset values: done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0; FSM goes to IDLE.
- IDLE state:
  - On the first edge where start=1, latch x0/y0/x1/y1/colour.
  - Clamp the latched coordinates: x>159 becomes 159, y>119 becomes 119.
  - Load the counters: cx=x0c, cy=y0c.
  - If x0c>x1c or y0c>y1c, the rectangle is empty: go directly to DONE with no plots.
  - Otherwise go to FILL.
- FILL state:
  - Every cycle register vga_x=cx, vga_y=cy, vga_colour=latched colour, vga_plot=1.
  - Scan is column-major: cy increments first; at cy==y1c, cy reloads y0c and cx increments.
  - When cx==x1c and cy==y1c, that pixel is the last plot; the next state is DONE.
- Timing:
  - The first vga_plot=1 appears on the edge after the start-sampling edge.
  - Exactly N=(x1c-x0c+1)*(y1c-y0c+1) consecutive plot cycles follow, with no gaps.
  - done=1 on the edge after the last plot, and vga_plot=0 on that same edge.
- DONE state:
  - done=1 and vga_plot=0.
  - Stay in DONE while start=1.
  - When start=0, return to IDLE; done=0 on that edge.
- Input handling:
  - start, x0/y0/x1/y1 and colour changes during FILL are ignored; parameters are latched once.
- Reset mid-fill:
  - Returns to IDLE; vga_plot=0 and done=0 on the reset edge.
  - No further plots occur.
  - A new start restarts from the new inputs.
- Widths and counters:
  - Counters are 8-bit (cx) and 7-bit (cy).
  - No arithmetic wrap is possible because coordinates are clamped before use.
  - vga_x/vga_y hold their last plotted value when vga_plot=0 (only the reset value is 0).
- Ownership:
  - The adapter treats vga_plot as the sole write qualifier.
  - When idle, the top level muxes other drawers onto the adapter.

Optional Feature:
- Macro: RECT_FILL_STRIPE_EN.
- Defined: vga_colour = cx[2:0] for each plotted pixel. This produces vertical 8-colour stripes, matching the lab's colour-by-column pattern. The colour input is ignored and not latched.
- Undefined: vga_colour is the latched colour input.
- Timing, pixel count and handshake are identical in both builds.

Test Plan:
- Full-screen fill: (0,0)-(159,119), colour=3, start held high.
  - Exactly 19200 plot cycles.
  - First plot (0,0), second plot (0,1), 121st plot (1,0), last plot (159,119).
  - done rises 1 cycle after the last plot; all plots have colour 3 (stripe build: colour = x mod 8).
- Single pixel: (10,20)-(10,20), colour=5 → exactly one plot at (10,20) colour 5, then done.
- Clamping: (150,110)-(200,127).
  - Exactly 10*10=100 plots; last at (159,119).
  - No coordinate exceeds 159 or 119.
- Empty rectangle: x0=50, x1=40 → zero plots; done=1 on the edge after start is sampled.
- Reset mid-fill: assert rst after 37 plots of a full-screen fill.
  - vga_plot=0 and done=0 from the reset edge onward.
  - Restarting with (0,0)-(1,1) gives exactly 4 plots.
- Handshake: hold start high for 5 cycles after done.
  - done stays 1 and no re-fill occurs.
  - Dropping start clears done on the next edge.
  - Changing colour mid-fill has no effect on plotted colour.
